// File: rtl/demod_segment_scheduler_if.sv
// rtl/demod_segment_scheduler_if.sv - channel request and pipeline-side signal bundle for the segment scheduler
interface demod_segment_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    req;
    logic [32*NUM_CH-1:0] data_in;
    logic [NUM_CH-1:0]    grant;
    logic [31:0]          dp_input_bit;
    logic                 dp_issue;
    logic                 res_valid;
    logic [CW-1:0]        res_channel;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  dp_input_bit,
        input  dp_issue,
        input  res_valid,
        input  res_channel
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output dp_input_bit,
        output dp_issue,
        output res_valid,
        output res_channel
    );
endinterface

// File: rtl/demod_segment_scheduler.sv
// rtl/demod_segment_scheduler.sv - round-robin burst scheduler feeding a fixed-latency demod segment pipeline
module demod_segment_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int LATENCY = 3,
    parameter int BURST   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    demod_segment_scheduler_if.slave bus,
    output logic                     busy,
    output logic                     idle
);
    localparam int              CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0]      BURST_MAX   = 4'(BURST);
    localparam logic [CW-1:0]   LAST_CH_RST = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ARB, SERVE, DRAIN} state_t;

    state_t                     state;
    logic [CW-1:0]              cur_ch;
    logic [CW-1:0]              last_ch;
    logic [3:0]                 burst_cnt;
    logic [LATENCY-1:0]         tag_v;
    logic [LATENCY-1:0][CW-1:0] tag_ch;

    logic [CW-1:0] arb_ch;
    logic [CW-1:0] cand;
    logic          arb_found;
    logic          issue;
    logic          serve_exit;
    logic          drain_done;

    // Cyclic search from last_ch+1; scanning downward lets the nearest requester overwrite farther ones.
    always_comb begin
        arb_found = 1'b0;
        arb_ch    = '0;
        cand      = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CW'((int'(last_ch) + i) % NUM_CH);
            if (bus.req[cand]) begin
                arb_found = 1'b1;
                arb_ch    = cand;
            end
        end
    end

    // Issue decision and steering of the granted channel's word into the pipeline.
    always_comb begin
        issue = (state == SERVE) && bus.req[cur_ch] && start && (burst_cnt < BURST_MAX);
        serve_exit = !issue || (burst_cnt == BURST_MAX - 4'd1);
        bus.dp_issue = issue;
        bus.grant = '0;
        bus.dp_input_bit = '0;
        if (issue) begin
            bus.grant[cur_ch] = 1'b1;
            bus.dp_input_bit  = bus.data_in[int'(cur_ch)*32 +: 32];
        end
    end

    // Drain may end once nothing valid would remain in the tag pipeline after this edge,
    // so busy drops right after the final result cycle.
    always_comb begin
        drain_done = !issue;
        for (int i = 0; i < LATENCY - 1; i++) begin
            if (tag_v[i]) drain_done = 1'b0;
        end
    end

    assign bus.res_valid   = tag_v[LATENCY-1];
    assign bus.res_channel = tag_ch[LATENCY-1];
    assign busy            = (state != IDLE) || (|tag_v);
    assign idle            = !busy;

    // Scheduler state machine: arbitration, burst counting and drain sequencing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cur_ch    <= '0;
            last_ch   <= LAST_CH_RST;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (|bus.req)) state <= ARB;
                end
                ARB: begin
                    if (arb_found) begin
                        cur_ch    <= arb_ch;
                        last_ch   <= arb_ch;
                        burst_cnt <= '0;
                        state     <= SERVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SERVE: begin
                    if (issue) burst_cnt <= burst_cnt + 4'd1;
                    if (serve_exit) begin
                        if (start && (|bus.req)) state <= ARB;
                        else if (!start)         state <= DRAIN;
                        else                     state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel tags travel alongside the pipeline so each result carries its owner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_v  <= '0;
            tag_ch <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_ch[0] <= cur_ch;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
        end
    end
endmodule
